// File: rtl/alu_cmd_master.sv
// Command master for a FIFO-fed ALU: it forwards host commands downstream and pairs returning results
// with their commands. Each response is flagged if its result differs from the locally computed value.
module alu_cmd_master #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_a,
   input  logic [3:0]             cmd_b,
   input  logic [1:0]             cmd_op,
   output logic [9:0]             data,
   output logic                   valid,
   input  logic                   ready,
   input  logic [8:0]             result,
   input  logic                   result_valid,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [8:0]             rsp_result,
   output logic [3:0]             rsp_a,
   output logic [3:0]             rsp_b,
   output logic [1:0]             rsp_op,
   output logic                   rsp_mismatch,
   output logic [$clog2(DEPTH):0] outstanding,
   output logic                   orphan_err,
   output logic                   timeout_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [OW-1:0] DEPTH_V   = OW'(DEPTH);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic [9:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic [OW-1:0]   out_q, out_d;

   logic [9:0]      pend_mem_q [DEPTH];
   logic [9:0]      pend_mem_d [DEPTH];
   logic [PW-1:0]   pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
   logic [OW-1:0]   pend_cnt_q, pend_cnt_d;

   logic [19:0]     rsp_mem_q [DEPTH];
   logic [19:0]     rsp_mem_d [DEPTH];
   logic [PW-1:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
   logic [OW-1:0]   rsp_cnt_q, rsp_cnt_d;

   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            orphan_q, orphan_d;
   logic            tmo_err_q, tmo_err_d;

   logic            accept, pend_push, pend_pop, rsp_pop;
   logic [9:0]      pend_head;
   logic [1:0]      head_op;
   logic [3:0]      head_a, head_b;
   logic [8:0]      expected;
   logic            check_en, mismatch;
   logic [19:0]     rsp_head;

   // Reference model for the oldest pending command; divide-by-zero is never flagged.
   always_comb begin
      pend_head = pend_mem_q[pend_rd_q];
      head_op   = pend_head[9:8];
      head_a    = pend_head[7:4];
      head_b    = pend_head[3:0];
      expected  = '0;
      check_en  = 1'b1;
      case (head_op)
         2'd0: expected = 9'(head_a) + 9'(head_b);
         2'd1: expected = 9'(head_a) - 9'(head_b);
         2'd2: expected = 9'(head_a) * 9'(head_b);
         default: begin
            if (head_b == 4'd0) check_en = 1'b0;
            else                expected = 9'(head_a) / 9'(head_b);
         end
      endcase
      mismatch = check_en && (result != expected);
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      valid_d    = valid_q;
      out_d      = out_q;
      pend_mem_d = pend_mem_q;
      pend_wr_d  = pend_wr_q;
      pend_rd_d  = pend_rd_q;
      pend_cnt_d = pend_cnt_q;
      rsp_mem_d  = rsp_mem_q;
      rsp_wr_d   = rsp_wr_q;
      rsp_rd_d   = rsp_rd_q;
      rsp_cnt_d  = rsp_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      orphan_d   = orphan_q;
      tmo_err_d  = tmo_err_q;
      pend_push  = 1'b0;

      cmd_ready = (state_q == IDLE) && (out_q < DEPTH_V);
      accept    = cmd_valid && cmd_ready;
      pend_pop  = result_valid && (pend_cnt_q != '0);
      rsp_pop   = (rsp_cnt_q != '0) && rsp_ready;

      case (state_q)
         IDLE: begin
            if (accept) begin
               data_d  = {cmd_op, cmd_b, cmd_a};
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         default: begin
            if (ready) begin
               valid_d   = 1'b0;
               pend_push = 1'b1;
               state_d   = IDLE;
            end
         end
      endcase

      // Pending entries are stored as {op, a, b}, unlike the {op, b, a} wire format.
      if (pend_push) begin
         pend_mem_d[pend_wr_q] = {data_q[9:8], data_q[3:0], data_q[7:4]};
         pend_wr_d = pend_wr_q + PW'(1);
      end
      if (pend_pop) begin
         pend_rd_d = pend_rd_q + PW'(1);
         rsp_mem_d[rsp_wr_q] = {result, head_op, head_a, head_b, mismatch};
         rsp_wr_d = rsp_wr_q + PW'(1);
      end
      if (rsp_pop) rsp_rd_d = rsp_rd_q + PW'(1);
      if (result_valid && (pend_cnt_q == '0)) orphan_d = 1'b1;

      case ({pend_push, pend_pop})
         2'b10:   pend_cnt_d = pend_cnt_q + OW'(1);
         2'b01:   pend_cnt_d = pend_cnt_q - OW'(1);
         default: pend_cnt_d = pend_cnt_q;
      endcase
      case ({pend_pop, rsp_pop})
         2'b10:   rsp_cnt_d = rsp_cnt_q + OW'(1);
         2'b01:   rsp_cnt_d = rsp_cnt_q - OW'(1);
         default: rsp_cnt_d = rsp_cnt_q;
      endcase
      case ({accept, rsp_pop})
         2'b10:   out_d = out_q + OW'(1);
         2'b01:   out_d = out_q - OW'(1);
         default: out_d = out_q;
      endcase

      if (result_valid || (pend_cnt_q == '0)) tmo_cnt_d = '0;
      else if (tmo_cnt_q != TIMEOUT_V)        tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (tmo_cnt_d == TIMEOUT_V) tmo_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         data_q     <= '0;
         valid_q    <= 1'b0;
         out_q      <= '0;
         pend_mem_q <= '{default: '0};
         pend_wr_q  <= '0;
         pend_rd_q  <= '0;
         pend_cnt_q <= '0;
         rsp_mem_q  <= '{default: '0};
         rsp_wr_q   <= '0;
         rsp_rd_q   <= '0;
         rsp_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         orphan_q   <= 1'b0;
         tmo_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         out_q      <= out_d;
         pend_mem_q <= pend_mem_d;
         pend_wr_q  <= pend_wr_d;
         pend_rd_q  <= pend_rd_d;
         pend_cnt_q <= pend_cnt_d;
         rsp_mem_q  <= rsp_mem_d;
         rsp_wr_q   <= rsp_wr_d;
         rsp_rd_q   <= rsp_rd_d;
         rsp_cnt_q  <= rsp_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         orphan_q   <= orphan_d;
         tmo_err_q  <= tmo_err_d;
      end
   end

   assign rsp_head     = rsp_mem_q[rsp_rd_q];
   assign data         = data_q;
   assign valid        = valid_q;
   assign rsp_valid    = (rsp_cnt_q != '0);
   assign rsp_result   = rsp_head[19:11];
   assign rsp_op       = rsp_head[10:9];
   assign rsp_a        = rsp_head[8:5];
   assign rsp_b        = rsp_head[4:1];
   assign rsp_mismatch = rsp_head[0];
   assign outstanding  = out_q;
   assign orphan_err   = orphan_q;
   assign timeout_err  = tmo_err_q;

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 SHALL have parameter DEPTH, default 4: maximum number of outstanding commands (power of 2, at least 2).
REQ-002 SHALL have parameter TIMEOUT, default 64: cycles allowed to wait for a result.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  host offers a command.
REQ-006 cmd_ready  output  1  block accepts the host command this cycle.
REQ-007 cmd_a, cmd_b  input  4 each  operands; cmd_op  input  2  opcode (0 add, 1 sub, 2 mul, 3 div).
REQ-008 data  output  10  packed command word {op[9:8], b[7:4], a[3:0]} to the ALU FIFO.
REQ-009 valid  output  1  data is offered downstream.
REQ-010 ready  input  1  downstream accepts data.
REQ-011 result  input  9  ALU result; result_valid  input  1  result present; there is no backpressure on results.
REQ-012 rsp_valid  output  1; rsp_ready  input  1  host response handshake.
REQ-013 rsp_result  output  9; rsp_a, rsp_b  output  4 each; rsp_op  output  2; rsp_mismatch  output  1.
REQ-014 outstanding  output  clog2(DEPTH)+1  count of commands accepted but not yet returned to the host.
REQ-015 orphan_err, timeout_err  output  1 each  sticky error flags.

Function
REQ-016 SHALL implement a transmit FSM with two states, IDLE and SEND.
REQ-017 cmd_ready SHALL be 1 only when the FSM is in IDLE and outstanding < DEPTH.
REQ-018 On an IDLE cycle with cmd_valid && cmd_ready: register data = {op,b,a}, set valid <= 1, increment outstanding, and go to SEND.
REQ-019 In SEND, data and valid SHALL stay stable until ready is sampled 1; on that edge set valid <= 0, push {op,a,b} into the pending FIFO (depth DEPTH), and return to IDLE. Throughput is at most one command per 2 cycles.
REQ-020 On result_valid with the pending FIFO non-empty, pop the oldest entry and push {result, op, a, b, mismatch} into the response FIFO (depth DEPTH).
REQ-021 Expected value, 9 bits:
- add: zero-extended a+b
- sub: (a-b) mod 512
- mul: a*b
- div with b != 0: floor(a/b)
REQ-022 mismatch SHALL be 1 when result != expected; for div with b == 0, mismatch SHALL be 0 (compare skipped).
REQ-023 The response FIFO SHALL be first-word-fall-through: rsp_valid = non-empty, and the entry is popped when rsp_valid && rsp_ready.
REQ-024 outstanding SHALL decrement on each response handshake; increment and decrement in the same cycle leave it unchanged.
REQ-025 Because outstanding is bounded by DEPTH, the pending and response FIFOs SHALL never overflow; FIFO pointers wrap modulo DEPTH.
REQ-026 result_valid with the pending FIFO empty (evaluated before any same-cycle push) SHALL drop the result and set orphan_err <= 1.
REQ-027 A pending push and a pending pop in the same cycle SHALL both take effect; the same applies to a response push and pop in the same cycle.
REQ-028 The timeout counter SHALL increment each cycle the pending FIFO is non-empty and result_valid is 0, and clear on result_valid or when the pending FIFO is empty.
REQ-029 When the timeout counter reaches TIMEOUT, timeout_err SHALL be set to 1 and the counter saturates.
REQ-030 Error flags SHALL stay set until reset and SHALL NOT stall operation.

Reset
REQ-031 While reset = 1 at a clock edge, the block SHALL set:
- valid = 0, data = 0, FSM = IDLE
- both FIFOs empty, rsp_valid = 0, outstanding = 0
- timeout counter = 0, orphan_err = 0, timeout_err = 0
REQ-032 cmd_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-033 Reset asserted mid-SEND SHALL drop valid at that edge and discard the in-flight command without waiting for ready.

Verification
REQ-034 add a=3, b=5 with ready tied 1, result=8 returned 3 cycles later -> rsp_result=8, rsp_op=0, rsp_mismatch=0; outstanding 1 -> 0 after the rsp handshake.
REQ-035 4 commands accepted with no results -> outstanding=4 and cmd_ready=0, 5th command held; one result plus one rsp handshake -> cmd_ready=1.
REQ-036 ready held 0 for 5 cycles in SEND -> data and valid unchanged; handshake on the 6th cycle -> valid=0 and FSM back in IDLE.
REQ-037 result_valid with nothing pending -> orphan_err=1 and rsp_valid stays 0; next command still round-trips correctly.
REQ-038 mul 7*9 with result=62 -> rsp_mismatch=1; div 9/0 with result=0 -> rsp_mismatch=0; sub 2-5 with result=509 -> rsp_mismatch=0.
REQ-039 One command with no result for 64 cycles -> timeout_err=1 on cycle 64; then reset -> every output at its REQ-031 value.
